// File: rtl/multi_pwm_shadow_if.sv
// multi_pwm_shadow_if
//   Addressed duty-write port of multi_pwm_shadow.
//   Wr   : one-cycle write strobe
//   Addr : channel index (indices >= channel count are dropped by the block)
//   Ton  : duty value for the shadow register of channel Addr
//   master drives the port, slave (the PWM block) receives it.
interface multi_pwm_shadow_if #(
   parameter int ADDR_W     = 5,
   parameter int RESOLUTION = 10
);
   logic                  Wr;
   logic [ADDR_W-1:0]     Addr;
   logic [RESOLUTION-1:0] Ton;

   modport master (output Wr, Addr, Ton);
   modport slave  (input  Wr, Addr, Ton);
endinterface

// File: rtl/multi_pwm_shadow.sv
// multi_pwm_shadow
//   Multi-channel PWM generator on one shared period counter. Each channel
//   has a shadow/active duty pair; shadows, the period top and the mode are
//   committed only on the edge that ends a period, so no partial period is
//   ever emitted.
//
//   Optional feature macro: MULTI_PWM_CENTER_EN
//     defined   -> Center port and up/down (center-aligned) counting exist
//     undefined -> edge-aligned counting only, no Center port
//
//   Ports
//     ClkIn     : clock, rising edge
//     nReset    : asynchronous active-low reset
//     wr_bus    : duty write port (Wr / Addr / Ton), slave side
//     Top       : period top value, sampled at each period boundary
//     oe        : per-channel output enable, takes effect one cycle later
//     Center    : 1 = center-aligned, sampled at period boundary (macro only)
//     PWMout    : registered PWM outputs
//     PeriodEnd : high during the last cycle of each period (combinational)
//     Pending   : channel holds a shadow duty not yet committed

// Per-channel shadow/active duty pair and registered comparator.
module multi_pwm_lane #(
   parameter int RESOLUTION = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr,
   input  logic [RESOLUTION-1:0] ton,
   input  logic                  commit,
   input  logic [RESOLUTION-1:0] cnt,
   input  logic                  en,
   output logic                  pwm,
   output logic                  pending
);
   logic [RESOLUTION-1:0] shadow;
   logic [RESOLUTION-1:0] active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
         pwm     <= 1'b0;
      end else begin
         pwm <= en && (cnt < active);
         if (wr)
            shadow <= ton;
         if (commit) begin
            pending <= 1'b0;
            // a write landing on the commit edge bypasses the shadow stage
            if (wr)
               active <= ton;
            else if (pending)
               active <= shadow;
         end else if (wr) begin
            pending <= 1'b1;
         end
      end
   end
endmodule

module multi_pwm_shadow #(
   parameter int NB_PWM     = 24,
   parameter int RESOLUTION = 10,
   parameter int ADDR_W     = 5     // 2**ADDR_W must cover NB_PWM
) (
   input  logic                  ClkIn,
   input  logic                  nReset,
   multi_pwm_shadow_if.slave     wr_bus,
   input  logic [RESOLUTION-1:0] Top,
   input  logic [NB_PWM-1:0]     oe,
`ifdef MULTI_PWM_CENTER_EN
   input  logic                  Center,
`endif
   output logic [NB_PWM-1:0]     PWMout,
   output logic                  PeriodEnd,
   output logic [NB_PWM-1:0]     Pending
);
   localparam logic [RESOLUTION-1:0] ONE = RESOLUTION'(1);

   logic [RESOLUTION-1:0] cnt, cnt_nxt;
   logic [RESOLUTION-1:0] top_act;
   logic                  dir_down, dir_nxt;
   logic                  center_act;
   logic                  last;

   // ---- state register ----
   always_ff @(posedge ClkIn or negedge nReset) begin
      if (!nReset) begin
         cnt      <= '0;
         dir_down <= 1'b0;
         top_act  <= '1;
      end else begin
         cnt      <= cnt_nxt;
         dir_down <= dir_nxt;
         if (last)
            top_act <= Top;
      end
   end

`ifdef MULTI_PWM_CENTER_EN
   always_ff @(posedge ClkIn or negedge nReset) begin
      if (!nReset)
         center_act <= 1'b0;
      else if (last)
         center_act <= Center;
   end
`else
   assign center_act = 1'b0;
`endif

   // ---- next-state ----
   // Center mode turns around at top_act; the turnaround cycle already
   // counts as "down" so a top of 1 ends its period on that same cycle.
   always_comb begin
      cnt_nxt = cnt + ONE;
      dir_nxt = dir_down;
      if (last) begin
         cnt_nxt = '0;
         dir_nxt = 1'b0;
      end else if (center_act && (dir_down || cnt == top_act)) begin
         cnt_nxt = cnt - ONE;
         dir_nxt = 1'b1;
      end
   end

   // ---- output (period end) ----
   always_comb begin
      if (!center_act)
         last = (cnt == top_act);
      else if (top_act == '0)
         last = 1'b1;                 // counter parked at 0, 1-cycle period
      else
         last = (cnt == ONE) && (dir_down || top_act == ONE);
   end

   assign PeriodEnd = last;

   // ---- channel lanes ----
   for (genvar i = 0; i < NB_PWM; i++) begin : g_lane
      multi_pwm_lane #(.RESOLUTION(RESOLUTION)) u_lane (
         .clk     (ClkIn),
         .rst_n   (nReset),
         .wr      (wr_bus.Wr && (wr_bus.Addr == ADDR_W'(i))),
         .ton     (wr_bus.Ton),
         .commit  (last),
         .cnt     (cnt),
         .en      (oe[i]),
         .pwm     (PWMout[i]),
         .pending (Pending[i])
      );
   end
endmodule

// File: tb/tb_multi_pwm_shadow.sv
module tb_multi_pwm_shadow;
   localparam int NB  = 24;
   localparam int RES = 10;
   localparam int AW  = 5;

   typedef struct {
      string         tag;
      logic [NB-1:0] pwm;
      logic          pe;
      logic [NB-1:0] pend;
   } exp_t;

   typedef struct {
      int j;
      int addr;
      int ton;
   } wr_t;

   logic           clk;
   logic           nReset;
   logic [RES-1:0] top_in;
   logic [NB-1:0]  oe_in;
   logic           center_in;
   logic [NB-1:0]  PWMout;
   logic           PeriodEnd;
   logic [NB-1:0]  Pending;

   multi_pwm_shadow_if #(.ADDR_W(AW), .RESOLUTION(RES)) bus ();

   multi_pwm_shadow #(.NB_PWM(NB), .RESOLUTION(RES), .ADDR_W(AW)) dut (
      .ClkIn     (clk),
      .nReset    (nReset),
      .wr_bus    (bus),
      .Top       (top_in),
      .oe        (oe_in),
`ifdef MULTI_PWM_CENTER_EN
      .Center    (center_in),
`endif
      .PWMout    (PWMout),
      .PeriodEnd (PeriodEnd),
      .Pending   (Pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   wr_t  wq[$];
   exp_t mon_e;

   // bench's view of the block, derived from the behavioural description
   int            b_top;
   logic          b_center;
   int            b_duty[NB];
   int            b_shadow[NB];
   logic [NB-1:0] b_pend;
   int            cnt_prev;
   int            duty_prev[NB];
   logic [NB-1:0] oe_prev;

   task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk({mon_e.tag, " pwm"},  PWMout, mon_e.pwm);
         chk({mon_e.tag, " pe"},   NB'(PeriodEnd), NB'(mon_e.pe));
         chk({mon_e.tag, " pend"}, Pending, mon_e.pend);
      end
   end

   task automatic model_reset();
      b_top    = (1 << RES) - 1;
      b_center = 1'b0;
      b_pend   = '0;
      cnt_prev = 0;
      oe_prev  = '0;
      for (int i = 0; i < NB; i++) begin
         b_duty[i] = 0; b_shadow[i] = 0; duty_prev[i] = 0;
      end
   endtask

   // Runs one period (or its first stop_at cycles), pushing the expected
   // outputs of every cycle and applying queued writes / input changes.
   task automatic run_period(input string tag, input int chg_j, input int chg_top,
                             input logic chg_center, input logic [NB-1:0] chg_oe,
                             input int stop_at);
      int   seq[$];
      exp_t e;
      bit   wr;
      int   wa, wt;
      seq = {};
      if (b_center && b_top == 0)
         seq.push_back(0);
      else begin
         for (int c = 0; c <= b_top; c++) seq.push_back(c);
         if (b_center)
            for (int c = b_top - 1; c >= 1; c--) seq.push_back(c);
      end
      for (int k = 0; k < seq.size(); k++) begin
         if (k == stop_at) begin
            bus.Wr = 1'b0;
            return;
         end
         if (k == chg_j) begin
            top_in    = RES'(chg_top);
            center_in = chg_center;
            oe_in     = chg_oe;
         end
         wr = 0; wa = 0; wt = 0;
         if (wq.size() > 0 && wq[0].j == k) begin
            wr = 1; wa = wq[0].addr; wt = wq[0].ton;
            void'(wq.pop_front());
         end
         bus.Wr   = wr;
         bus.Addr = AW'(wa);
         bus.Ton  = RES'(wt);
         e.tag = $sformatf("%s[%0d]", tag, k);
         for (int i = 0; i < NB; i++)
            e.pwm[i] = oe_prev[i] && (cnt_prev < duty_prev[i]);
         e.pe   = (k == seq.size() - 1);
         e.pend = b_pend;
         sb.push_back(e);
         cnt_prev  = seq[k];
         duty_prev = b_duty;
         oe_prev   = oe_in;
         @(posedge clk); #1;
         if (k == seq.size() - 1) begin
            b_top    = int'(top_in);
            b_center = center_in;
            for (int i = 0; i < NB; i++) begin
               if (wr && wa == i) begin
                  b_duty[i] = wt; b_shadow[i] = wt; b_pend[i] = 1'b0;
               end else if (b_pend[i]) begin
                  b_duty[i] = b_shadow[i]; b_pend[i] = 1'b0;
               end
            end
         end else if (wr && wa < NB) begin
            b_shadow[wa] = wt;
            b_pend[wa]   = 1'b1;
         end
      end
      bus.Wr = 1'b0;
   endtask

   initial begin
      exp_t z;
      logic [NB-1:0] oe_no0;
      nReset = 1'b1; top_in = '0; oe_in = '0; center_in = 1'b0;
      bus.Wr = 1'b0; bus.Addr = '0; bus.Ton = '0;
      model_reset();
      #2 nReset = 1'b0;
      @(posedge clk); #1;
      z.pwm = '0; z.pe = 1'b0; z.pend = '0;
      for (int r = 0; r < 2; r++) begin
         z.tag = $sformatf("reset[%0d]", r);
         sb.push_back(z);
         @(posedge clk); #1;
      end
      nReset = 1'b1;

      // first period after reset is 2^RES cycles; stage writes meanwhile
      top_in = 9; oe_in = '1;
      wq.push_back('{0, 0, 3});
      wq.push_back('{5, 31, 5});     // out-of-range channel: dropped
      wq.push_back('{10, 2, 0});
      wq.push_back('{11, 4, 12});    // above top: constant high
      run_period("first", -1, 0, 1'b0, '1, -1);

      // double write on ch1, write on the commit edge for ch3
      wq.push_back('{2, 1, 5});
      wq.push_back('{4, 1, 7});
      wq.push_back('{9, 3, 4});
      run_period("p2", -1, 0, 1'b0, '1, -1);

      // lower Top mid-period (no effect until boundary), drop oe[0]
      oe_no0 = '1; oe_no0[0] = 1'b0;
      run_period("p3", 2, 4, 1'b0, oe_no0, -1);
      run_period("p4", 0, 9, 1'b0, '1, -1);

      // reset in the middle of an active period with a pending shadow
      wq.push_back('{1, 5, 2});
      run_period("pre_rst", -1, 0, 1'b0, '1, 6);
      #2 nReset = 1'b0;
      #1;
      chk("async_rst pwm",  PWMout, '0);
      chk("async_rst pend", Pending, '0);
      chk("async_rst pe",   NB'(PeriodEnd), '0);
      model_reset();
      @(posedge clk); #1;
      nReset = 1'b1;
      run_period("post_rst",  -1, 0, 1'b0, '1, -1);
      run_period("post_rst2", -1, 0, 1'b0, '1, -1);

`ifdef MULTI_PWM_CENTER_EN
      // arm center mode mid-period: current edge period stays 10 cycles
      wq.push_back('{0, 6, 3});
      run_period("c_arm",   3, 8, 1'b1, '1, -1);
      run_period("center",  -1, 0, 1'b0, '1, -1);
      run_period("center2", -1, 0, 1'b0, '1, -1);
      run_period("c_off",   5, 8, 1'b0, '1, -1);
      run_period("edge_back", -1, 0, 1'b0, '1, -1);
`endif

      @(negedge clk); #1;
      chk("sb_drain", NB'(sb.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/multi_pwm_shadow.md
# multi_pwm_shadow

Multi-channel PWM generator driven by one shared period counter. Each channel has a double-buffered duty register, and the period length is programmable at run time. Duty and period updates are committed only at the period boundary, so outputs never show partial or glitched periods. This block replaces per-channel free-running PWM instances in the actuator/LED output stage. Channels are written through one addressed port instead of per-channel latch strobes.

## Interface
- NB_PWM, 24, number of PWM channels
- RESOLUTION, 10, width in bits of the counter, duty and period values
- ADDR_W, 5, channel address width; must satisfy 2^ADDR_W >= NB_PWM
- ClkIn  in  1  single clock; all logic on its rising edge
- nReset  in  1  asynchronous active-low reset
- Top  in  RESOLUTION  period top value; sampled at each period boundary
- Wr  in  1  duty write strobe, one cycle per write
- Addr  in  ADDR_W  channel index for Wr
- Ton  in  RESOLUTION  duty value written to the shadow register of channel Addr
- oe  in  NB_PWM  per-channel output enable, synchronous
- Center  in  1  1 = center-aligned mode, sampled at period boundary (present only with MULTI_PWM_CENTER_EN)
- PWMout  out  NB_PWM  registered PWM outputs
- PeriodEnd  out  1  high during the last cycle of each period
- Pending  out  NB_PWM  channel has a shadow value not yet committed

## Operation
- **Reset values.** cnt=0, TopAct=2^RESOLUTION-1, every active duty=0, every shadow=0, Pending=0, PWMout=0, PeriodEnd=0, direction=up, CenterAct=0.
- **Writes.**
  - A write stores Ton into shadow[Addr] and sets Pending[Addr].
  - Writes with Addr >= NB_PWM are ignored.
  - A second write before the boundary overwrites the shadow; only the last value is committed.
- **Edge mode.**
  - Sequence is 0,1,…,TopAct, then back to 0.
  - Period = TopAct+1 cycles.
  - Last cycle of the period: cnt==TopAct.
- **Center mode.**
  - Sequence is 0,1,…,TopAct,TopAct-1,…,1, then back to 0.
  - Period = 2·TopAct cycles.
  - Last cycle: cnt==1 while counting down.
  - If TopAct==0, cnt holds 0 and the period is 1 cycle.
- **PeriodEnd** is asserted combinationally from the last-cycle condition.
- **Commit** happens on the clock edge that ends a period:
  - TopAct ← Top.
  - CenterAct ← Center.
  - For each Pending channel: active ← shadow, then Pending cleared.
  - Counter restarts at 0, direction up.
- **Write on a commit edge.** A write in the same cycle as PeriodEnd to channel k commits the new Ton immediately, and Pending[k] stays 0.
- **Compare.** PWMout[i] ← oe[i] & (cnt < active[i]), registered.
  - active=0 gives constant 0.
  - active > TopAct (edge mode) or active > TopAct (center mode, covering all values) gives constant 1.
- **Width rules.** All comparisons are unsigned and RESOLUTION bits wide. The counter never exceeds TopAct.
- **Top lowered mid-period.** No effect until the boundary.
- **Reset mid-period.** Immediate return to reset values; uncommitted shadows are lost.

## Timing
- PWMout lags cnt by 1 cycle; PeriodEnd is not delayed.
- Write-to-output latency: the new duty is first visible on PWMout 1 cycle after the first cnt=0 following the commit edge.
- oe change reaches PWMout 1 cycle later.
- Pending rises 1 cycle after Wr and falls on the commit edge.

## Configuration
- **MULTI_PWM_CENTER_EN defined:**
  - The Center port and the up/down counter are included.
  - Mode switches only at a period boundary.
- **MULTI_PWM_CENTER_EN undefined:**
  - The Center port is absent.
  - CenterAct is constant 0 and only edge mode exists.
  - All other behaviour is identical.

## Test plan
- **Reset.** Assert nReset=0 mid-period with outputs active → PWMout=0, Pending=0, PeriodEnd=0 immediately. After release, the first period is 1024 cycles.
- **Basic duty.** Top=9, write ch0 Ton=3, oe[0]=1 → after the next boundary, PWMout[0] is high 3 of every 10 cycles and PeriodEnd pulses every 10 cycles.
- **Double write.** Write ch1 Ton=5, then Ton=7, mid-period → Pending[1]=1 until the boundary, then exactly 7-high/3-low with no 5-cycle period.
- **Extremes.** Ton=0 → PWMout[2] constantly 0. Ton=12 with Top=9 → constantly 1. Address 31 with NB_PWM=24 → no state change.
- **Write on commit edge.** Wr to ch3 with Ton=4 in the PeriodEnd cycle → committed at that edge, Pending[3] never asserted, 4-high in the next period.
- **Center mode (MULTI_PWM_CENTER_EN).** Center=1, Top=8, Ton=3 → 16-cycle period with a contiguous 5-cycle high pulse across the wrap (cnt 2,1,0,1,2). Toggling Center mid-period takes effect only at the boundary.
